lcd_fb_arbiter: RTL and testbench
=================================

# lcd_fb_arbiter

Arbiter and sequencer for the single-port 1024×8 LCD frame-buffer RAM. It shares the RAM between two requesters: the LCD refresh reader, which streams page/column bytes to the serial LCD engine, and a pixel writer, such as a drawing or key-driven update source. It also runs a built-in clear sequence that fills the whole buffer with one byte value. It sits between the frame-buffer RAM and its clients, and is the only block that drives the RAM port.

## Interface
- `ADDR_W`, 10, RAM address width (1024 bytes = 8 pages × 128 columns)
- `DATA_W`, 8, RAM data width
- `MAX_RD_BURST`, 4, number of consecutive cycles a pending write may lose to reads before it is forced through
- `clk`  in  1  system clock; all state updates on posedge
- `rst`  in  1  asynchronous, active-high reset
- `rd_req`  in  1  read request from the refresh reader
- `rd_addr`  in  ADDR_W  read address
- `rd_ack`  out  1  read granted this cycle (combinational)
- `rd_valid`  out  1  `rd_data` valid; registered, one cycle after `rd_ack`
- `rd_data`  out  DATA_W  equals `ram_rdata` when `rd_valid` is high, else 0
- `wr_req`  in  1  write request from the pixel writer
- `wr_addr`  in  ADDR_W  write address
- `wr_data`  in  DATA_W  write data
- `wr_ack`  out  1  write granted this cycle (combinational)
- `clr_start`  in  1  single-cycle pulse that starts a full-buffer clear
- `clr_value`  in  DATA_W  fill byte; sampled on the `clr_start` cycle
- `clr_busy`  out  1  clear sequence in progress
- `clr_done`  out  1  single-cycle pulse after the last clear write
- `ram_addr`  out  ADDR_W  RAM address (combinational)
- `ram_wdata`  out  DATA_W  RAM write data (combinational)
- `ram_we`  out  1  RAM write enable (combinational)
- `ram_rdata`  in  DATA_W  RAM read data; synchronous RAM, valid the cycle after the address is presented

## Operation
- The FSM has two states, ARB and CLEAR. Reset puts it in ARB.
- **ARB, only one requester active:** that requester is granted immediately.
- **ARB, both requesters active:** the read is granted unless `starve_cnt == MAX_RD_BURST`. In that case the write is granted and `starve_cnt` is cleared.
- **`starve_cnt` update:**
  - increments on every cycle where `wr_req` is high and `wr_ack` is low;
  - clears on `wr_ack`, or when `wr_req` is low;
  - saturates at `MAX_RD_BURST`.
- **RAM port by grant:**
  - read grant: `ram_addr = rd_addr`, `ram_we = 0`;
  - write grant: `ram_addr = wr_addr`, `ram_wdata = wr_data`, `ram_we = 1`;
  - no grant: `ram_addr = 0`, `ram_wdata = 0`, `ram_we = 0`.
- **Entering CLEAR:** `clr_start` in ARB latches `clr_value` into `fill_q` and moves to CLEAR on the next cycle. Requests on that same cycle are still arbitrated normally.
- **CLEAR:**
  - `rd_ack` and `wr_ack` are held at 0;
  - each cycle drives `ram_we = 1`, `ram_addr = clr_cnt`, `ram_wdata = fill_q`;
  - `clr_cnt` counts 0..1023, one write per cycle;
  - after the write to 1023, the FSM returns to ARB and `clr_cnt` resets to 0.
- `clr_start` during CLEAR is ignored; the fill value is not re-latched.
- A read granted on the last ARB cycle before CLEAR still produces its `rd_valid` in the first CLEAR cycle.
- Requesters hold `req`, `addr` and `data` stable until they see their ack. An ack means the transaction has completed on the RAM port.

## Timing
- **Reset values:** `rd_valid = 0`, `rd_data = 0`, `clr_busy = 0`, `clr_done = 0`, `ram_we = 0`, `ram_addr = 0`, `ram_wdata = 0`, `rd_ack = 0`, `wr_ack = 0`; `starve_cnt = 0`, `clr_cnt = 0`, state = ARB.
- **Read latency:** `rd_ack` at cycle N gives `rd_valid` high and `rd_data` = RAM[`rd_addr`] at cycle N+1. Back-to-back reads sustain 1 byte per cycle.
- **Write:** takes effect at the posedge that ends the `wr_ack` cycle. A read of the same address on the next cycle returns the new data.
- **Clear timing:**
  - `clr_busy` is high from cycle S+1 through S+1024, where S is the `clr_start` cycle;
  - `clr_done` is high in cycle S+1025;
  - ARB service resumes in cycle S+1025.
- **Async reset mid-clear:** `clr_busy` drops immediately and the partial fill is abandoned with no `clr_done`. A pending `rd_valid` is also dropped.
- **Worst-case write wait:** with continuous reads, a write waits `MAX_RD_BURST` cycles and is acked on the next cycle (5 cycles at default), excluding CLEAR time.

## Test plan
- **Single read:** RAM[0x085] = 0xA5; assert `rd_req` with `rd_addr` = 0x085 → `rd_ack` in the same cycle, `rd_valid` with `rd_data` = 0xA5 on the next cycle.
- **Write then read:** `wr_req` with `wr_addr` = 0x3FF, `wr_data` = 0x5A → `wr_ack` and `ram_we` for 1 cycle; a subsequent read of 0x3FF returns 0x5A.
- **Starvation limit:** `rd_req` held continuously and `wr_req` raised at cycle 0 → `rd_ack` on cycles 0–3, `wr_ack` on cycle 4, reads resume on cycle 5.
- **Full clear:** pulse `clr_start` with `clr_value` = 0xFF while `rd_req` is held → `clr_busy` for exactly 1024 cycles, `ram_we` = 1 with addresses 0..1023 in order, no acks, one `clr_done` pulse; every address then reads back 0xFF.
- **`clr_start` during clear:** a second pulse with `clr_value` = 0x00 at clear cycle 500 → ignored; the fill stays 0xFF and `clr_done` timing is unchanged.
- **Reset mid-clear:** assert `rst` at clear cycle 300 → all outputs go to reset values immediately; after release, reads and writes are granted normally and no `clr_done` appears.

Source files
------------

// File: rtl/lcd_fb_arbiter.sv
// lcd_fb_arbiter: owns the single-port frame-buffer RAM. Arbitrates between the
// LCD refresh reader and the pixel writer, with a bound on how long a write can
// lose to reads. Also runs a built-in sequence that fills every byte with one value.
module lcd_fb_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 8,
  parameter int MAX_RD_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_value,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int SW = $clog2(MAX_RD_BURST + 1);
  localparam logic [SW-1:0]     STARVE_MAX = SW'(MAX_RD_BURST);
  localparam logic [ADDR_W-1:0] CLR_LAST   = {ADDR_W{1'b1}};

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [SW-1:0]     starve_cnt;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] fill_q;
  logic              rd_valid_q;
  logic              clr_done_q;
  logic              rd_grant;
  logic              wr_grant;

  // Grant decision, RAM port mux and next-state selection.
  // Grants are suppressed while rst is high so every output sits at its reset value.
  always_comb begin
    state_next = state;
    rd_grant   = 1'b0;
    wr_grant   = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    ram_we     = 1'b0;
    if (rst) begin
      state_next = ARB;
    end else begin
      case (state)
        ARB: begin
          if (rd_req && wr_req) begin
            // Reads win unless the write has already waited its full allowance.
            if (starve_cnt == STARVE_MAX) begin
              wr_grant = 1'b1;
            end else begin
              rd_grant = 1'b1;
            end
          end else begin
            rd_grant = rd_req;
            wr_grant = wr_req;
          end
          if (wr_grant) begin
            ram_addr  = wr_addr;
            ram_wdata = wr_data;
            ram_we    = 1'b1;
          end else if (rd_grant) begin
            ram_addr  = rd_addr;
          end else begin
            ram_addr  = '0;
          end
          if (clr_start) begin
            state_next = CLEAR;
          end else begin
            state_next = ARB;
          end
        end
        CLEAR: begin
          ram_we    = 1'b1;
          ram_addr  = clr_cnt;
          ram_wdata = fill_q;
          if (clr_cnt == CLR_LAST) begin
            state_next = ARB;
          end else begin
            state_next = CLEAR;
          end
        end
        default: begin
          state_next = ARB;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB;
    end else begin
      state <= state_next;
    end
  end

  // Count consecutive cycles a pending write has been refused, saturating at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (wr_req && !wr_grant) begin
      if (starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  // Clear address counter and fill byte; the fill is only captured from ARB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt <= '0;
      fill_q  <= '0;
    end else if (state == CLEAR) begin
      clr_cnt <= (clr_cnt == CLR_LAST) ? '0 : clr_cnt + ADDR_W'(1);
    end else begin
      clr_cnt <= '0;
      if (clr_start) begin
        fill_q <= clr_value;
      end
    end
  end

  // Read-valid tracks the synchronous RAM latency; done pulses after the last fill write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_grant;
      clr_done_q <= (state == CLEAR) && (clr_cnt == CLR_LAST);
    end
  end

  assign rd_ack   = rd_grant;
  assign wr_ack   = wr_grant;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_valid_q ? ram_rdata : '0;
  assign clr_busy = (state == CLEAR);
  assign clr_done = clr_done_q;

endmodule

// File: tb/tb_lcd_fb_arbiter.sv
// Bench for lcd_fb_arbiter: a synchronous RAM model on the RAM port plus a
// behavioural reference (expected memory image, write wait count, clear progress).
module tb_lcd_fb_arbiter;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int MAXB   = 4;
  localparam int DEPTH  = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd_req, rd_ack, rd_valid, wr_req, wr_ack, clr_start, clr_busy, clr_done, ram_we;
  logic [ADDR_W-1:0] rd_addr, wr_addr, ram_addr;
  logic [DATA_W-1:0] rd_data, wr_data, clr_value, ram_wdata, ram_rdata;

  lcd_fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RD_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .clr_start(clr_start), .clr_value(clr_value), .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Initial RAM contents, shared formula for the RAM and the expected image.
  function automatic logic [7:0] init_byte(input int i);
    if (i == 'h085) return 8'hA5;
    return 8'(i * 7 + 19);
  endfunction

  // Synchronous single-port frame-buffer RAM.
  logic [7:0] mem [0:DEPTH-1];
  logic init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_byte(i);
      init_done <= 1'b1;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  // Reference model state.
  logic [7:0] exp_mem [0:DEPTH-1];
  int         m_wait, m_idx;
  bit         m_clearing, m_done, m_rv;
  logic [7:0] m_fill, m_rd;
  bit         e_rd_ack, e_wr_ack, e_we, e_busy, e_done, e_rv;
  logic [9:0] e_addr;
  logic [7:0] e_wdata, e_rd;
  int vectors = 0;
  int miscompares = 0;

  function automatic void model_reset();
    m_wait = 0; m_idx = 0; m_clearing = 0; m_done = 0; m_rv = 0; m_rd = 8'h00;
  endfunction

  // Produce this cycle's expectations from the current inputs, then advance the model.
  function automatic void model_step();
    e_rd_ack = 0; e_wr_ack = 0; e_we = 0; e_addr = 10'h000; e_wdata = 8'h00;
    e_busy = m_clearing; e_done = m_done; e_rv = m_rv; e_rd = m_rv ? m_rd : 8'h00;
    if (m_clearing) begin
      e_we = 1; e_addr = 10'(m_idx); e_wdata = m_fill;
    end else if (wr_req && (!rd_req || m_wait >= MAXB)) begin
      e_wr_ack = 1; e_we = 1; e_addr = wr_addr; e_wdata = wr_data;
    end else if (rd_req) begin
      e_rd_ack = 1; e_addr = rd_addr;
    end
    m_wait = (wr_req && !e_wr_ack) ? m_wait + 1 : 0;
    m_rv = e_rd_ack;
    m_rd = exp_mem[rd_addr];
    m_done = 0;
    if (e_we) exp_mem[e_addr] = e_wdata;
    if (m_clearing) begin
      m_idx++;
      if (m_idx == DEPTH) begin m_clearing = 0; m_idx = 0; m_done = 1; end
    end else if (clr_start) begin
      m_clearing = 1; m_fill = clr_value; m_idx = 0;
    end
  endfunction

  task automatic apply(input logic rr, input logic [9:0] ra, input logic wr, input logic [9:0] wa,
                       input logic [7:0] wd, input logic cs, input logic [7:0] cv);
    @(negedge clk);
    rd_req = rr; rd_addr = ra; wr_req = wr; wr_addr = wa; wr_data = wd;
    clr_start = cs; clr_value = cv;
    #1;
    model_step();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; rd_req = 1'b1; wr_req = 1'b1; rd_addr = 10'h155; wr_addr = 10'h2AA;
    wr_data = 8'h77; clr_start = 1'b1; clr_value = 8'h11;
    #1;
    vectors++;
    if ({rd_ack, wr_ack, ram_we, clr_busy, clr_done, rd_valid} !== 6'b000000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 000000", {rd_ack, wr_ack, ram_we, clr_busy, clr_done, rd_valid});
    end
    vectors++;
    if ({ram_addr, ram_wdata, rd_data} !== 26'h0) begin
      miscompares++;
      $display("FAIL reset_bus: got addr=%h wdata=%h rdata=%h expected all 0", ram_addr, ram_wdata, rd_data);
    end
    @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b0; clr_start = 1'b0; rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single_read();
    apply(1'b1, 10'h085, 1'b0, 10'h000, 8'h00, 1'b0, 8'h00);
    vectors++;
    if (rd_ack !== 1'b1 || ram_addr !== 10'h085 || ram_we !== 1'b0) begin
      miscompares++;
      $display("FAIL single_read_ack: got ack=%b addr=%h we=%b expected 1 085 0", rd_ack, ram_addr, ram_we);
    end
    apply(1'b0, 10'h000, 1'b0, 10'h000, 8'h00, 1'b0, 8'h00);
    vectors++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin
      miscompares++;
      $display("FAIL single_read_data: got valid=%b data=%h expected 1 a5", rd_valid, rd_data);
    end
  endtask

  task automatic test_write_read();
    apply(1'b0, 10'h000, 1'b1, 10'h3FF, 8'h5A, 1'b0, 8'h00);
    vectors++;
    if (wr_ack !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 10'h3FF || ram_wdata !== 8'h5A) begin
      miscompares++;
      $display("FAIL write_port: got ack=%b we=%b addr=%h wdata=%h expected 1 1 3ff 5a", wr_ack, ram_we, ram_addr, ram_wdata);
    end
    apply(1'b1, 10'h3FF, 1'b0, 10'h000, 8'h00, 1'b0, 8'h00);
    vectors++;
    if (ram_we !== 1'b0 || rd_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL write_one_cycle: got we=%b rd_ack=%b expected 0 1", ram_we, rd_ack);
    end
    apply(1'b0, 10'h000, 1'b0, 10'h000, 8'h00, 1'b0, 8'h00);
    vectors++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h5A) begin
      miscompares++;
      $display("FAIL write_readback: got valid=%b data=%h expected 1 5a", rd_valid, rd_data);
    end
  endtask

  task automatic test_starvation();
    logic wp = 1'b1;
    logic [9:0] ra = 10'($urandom);
    for (int c = 0; c < 7; c++) begin
      apply(1'b1, ra, wp, 10'h2C4, 8'h9E, 1'b0, 8'h00);
      vectors++;
      if (rd_ack !== (c != 4) || wr_ack !== (c == 4)) begin
        miscompares++;
        $display("FAIL starve_cycle%0d: got rd_ack=%b wr_ack=%b expected %b %b", c, rd_ack, wr_ack, c != 4, c == 4);
      end
      vectors++;
      if (rd_valid !== e_rv || rd_data !== e_rd) begin
        miscompares++;
        $display("FAIL starve_data%0d: got %b/%h expected %b/%h", c, rd_valid, rd_data, e_rv, e_rd);
      end
      if (e_wr_ack) wp = 1'b0;
      if (e_rd_ack) ra = 10'($urandom);
    end
    apply(1'b0, 10'h000, 1'b0, 10'h000, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic test_random(input int n);
    logic rp = 1'b0, wp = 1'b0;
    logic [9:0] ra = 10'h0, wa = 10'h0;
    logic [7:0] wd = 8'h0;
    for (int c = 0; c < n + 10; c++) begin
      if (c < n && !rp && $urandom_range(0, 3) != 0) begin rp = 1'b1; ra = 10'($urandom_range(0, 63)); end
      if (c < n && !wp && $urandom_range(0, 2) == 0) begin
        wp = 1'b1; wa = 10'($urandom_range(0, 63)); wd = 8'($urandom);
      end
      apply(rp, ra, wp, wa, wd, 1'b0, 8'h00);
      vectors++;
      if ({rd_ack, wr_ack, ram_we, ram_addr, clr_busy, clr_done, rd_valid, rd_data} !==
          {e_rd_ack, e_wr_ack, e_we, e_addr, e_busy, e_done, e_rv, e_rd}) begin
        miscompares++;
        $display("FAIL random_c%0d: got %h expected %h (ack_r,ack_w,we,addr,busy,done,valid,data)", c,
                 {rd_ack, wr_ack, ram_we, ram_addr, clr_busy, clr_done, rd_valid, rd_data},
                 {e_rd_ack, e_wr_ack, e_we, e_addr, e_busy, e_done, e_rv, e_rd});
      end
      if (e_we) begin
        vectors++;
        if (ram_wdata !== e_wdata) begin
          miscompares++;
          $display("FAIL random_wdata%0d: got %h expected %h", c, ram_wdata, e_wdata);
        end
      end
      if (e_rd_ack) rp = 1'b0;
      if (e_wr_ack) wp = 1'b0;
    end
  endtask

  task automatic test_clear();
    apply(1'b1, 10'h040, 1'b0, 10'h000, 8'h00, 1'b1, 8'hFF);
    vectors++;
    if (rd_ack !== 1'b1 || clr_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_start_cycle: got rd_ack=%b busy=%b expected 1 0", rd_ack, clr_busy);
    end
    for (int i = 0; i < DEPTH; i++) begin
      apply(1'b1, 10'h040, 1'b0, 10'h000, 8'h00, i == 500, 8'h00);
      vectors++;
      if ({clr_busy, ram_we, rd_ack, wr_ack, clr_done} !== 5'b11000 || ram_addr !== 10'(i) || ram_wdata !== 8'hFF) begin
        miscompares++;
        $display("FAIL clear_cycle%0d: got busy,we,ra,wa,done=%b addr=%h wdata=%h expected 11000 %h ff",
                 i, {clr_busy, ram_we, rd_ack, wr_ack, clr_done}, ram_addr, ram_wdata, 10'(i));
      end
      if (i == 0) begin
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== e_rd) begin
          miscompares++;
          $display("FAIL clear_pending_read: got %b/%h expected 1/%h", rd_valid, rd_data, e_rd);
        end
      end
    end
    apply(1'b1, 10'h040, 1'b0, 10'h000, 8'h00, 1'b0, 8'h00);
    vectors++;
    if (clr_done !== 1'b1 || clr_busy !== 1'b0 || rd_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_done: got done=%b busy=%b rd_ack=%b expected 1 0 1", clr_done, clr_busy, rd_ack);
    end
    for (int a = 0; a <= DEPTH; a++) begin
      apply(a < DEPTH, 10'(a), 1'b0, 10'h000, 8'h00, 1'b0, 8'h00);
      vectors++;
      if (rd_valid !== 1'b1 || rd_data !== 8'hFF || clr_done !== 1'b0) begin
        miscompares++;
        $display("FAIL clear_readback%0d: got valid=%b data=%h done=%b expected 1 ff 0", a, rd_valid, rd_data, clr_done);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    apply(1'b0, 10'h000, 1'b0, 10'h000, 8'h00, 1'b1, 8'h3C);
    for (int i = 0; i < 300; i++) begin
      apply(1'b0, 10'h000, 1'b0, 10'h000, 8'h00, 1'b0, 8'h00);
      vectors++;
      if (clr_busy !== 1'b1 || ram_addr !== 10'(i) || ram_wdata !== 8'h3C) begin
        miscompares++;
        $display("FAIL midclr_cycle%0d: got busy=%b addr=%h wdata=%h expected 1 %h 3c", i, clr_busy, ram_addr, ram_wdata, 10'(i));
      end
    end
    @(negedge clk);
    rst = 1'b1; rd_req = 1'b1; rd_addr = 10'h010; wr_req = 1'b1; wr_addr = 10'h123;
    #1;
    vectors++;
    if ({clr_busy, clr_done, ram_we, rd_ack, wr_ack, rd_valid} !== 6'b0 || ram_addr !== 10'h0 || rd_data !== 8'h0) begin
      miscompares++;
      $display("FAIL midclr_reset: got flags=%b addr=%h rdata=%h expected 0", {clr_busy, clr_done, ram_we, rd_ack, wr_ack, rd_valid}, ram_addr, rd_data);
    end
    @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b0; rst = 1'b0;
    model_reset();
    apply(1'b1, 10'd299, 1'b0, 10'h000, 8'h00, 1'b0, 8'h00);
    apply(1'b1, 10'd300, 1'b0, 10'h000, 8'h00, 1'b0, 8'h00);
    vectors++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h3C || clr_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midclr_last_filled: got valid=%b data=%h busy=%b expected 1 3c 0", rd_valid, rd_data, clr_busy);
    end
    apply(1'b0, 10'h000, 1'b1, 10'h123, 8'hC7, 1'b0, 8'h00);
    vectors++;
    if (rd_valid !== 1'b1 || rd_data !== e_rd || wr_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL midclr_unfilled: got valid=%b data=%h wr_ack=%b expected 1 %h 1", rd_valid, rd_data, wr_ack, e_rd);
    end
    test_random(1100);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = init_byte(i);
    model_reset();
    rd_req = 1'b0; rd_addr = 10'h0; wr_req = 1'b0; wr_addr = 10'h0; wr_data = 8'h0;
    clr_start = 1'b0; clr_value = 8'h0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single_read();
    test_write_read();
    test_starvation();
    test_random(600);
    test_clear();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
